// File: rtl/adder_chain_sequencer_if.sv
// Byte-stream bundle for adder_chain_sequencer: operand input stream and result output stream.
// slave is the sequencer side, master is the producer/consumer side.
interface adder_chain_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/adder_chain_sequencer.sv
// Sequences a shared external 8-bit adder to perform an NBYTES-wide add one byte lane at a
// time, little-endian, chaining carry between lanes. Results are buffered and streamed out,
// followed by one carry byte flagged with out_last.
// Optional feature: define ADDER_SUB_MODE_EN to add the sub port (A-B, carry byte = no-borrow).
module adder_chain_sequencer #(
  parameter int unsigned NBYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
`ifdef ADDER_SUB_MODE_EN
  input  logic                    sub,
`endif
  adder_chain_sequencer_if.slave  bus,
  output logic                    busy,
  output logic [7:0]              add_a,
  output logic [7:0]              add_b,
  output logic                    add_cin,
  input  logic [7:0]              add_sum,
  input  logic                    add_cout
);

  localparam int unsigned IdxW = $clog2(NBYTES + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [2:0] {StLoadA, StLoadB, StAdd, StEmit, StEmitC} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   oidx_q, oidx_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [7:0]        result_q [NBYTES];
  logic [7:0]        result_d [NBYTES];
  // Low until the first clock after reset release so in_ready stays low through reset.
  logic              live_q;
  logic              sub_in;
  logic              in_fire, out_fire;

`ifdef ADDER_SUB_MODE_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Handshake and adder-facing outputs, decoded from registered state only.
  always_comb begin
    bus.in_ready  = live_q && ena && (state_q == StLoadA || state_q == StLoadB);
    bus.out_valid = ena && (state_q == StEmit || state_q == StEmitC);
    bus.out_last  = (state_q == StEmitC);
    bus.out_data  = 8'h00;
    if (state_q == StEmit) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (oidx_q == IdxW'(i)) bus.out_data = result_q[i];
      end
    end else if (state_q == StEmitC) begin
      bus.out_data = {7'b0, carry_q};
    end
    busy    = !(state_q == StLoadA && idx_q == '0);
    add_a   = a_q;
    add_b   = sub_q ? ~b_q : b_q;
    add_cin = carry_q;
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
  end

  // Next-state logic; everything holds when ena is low.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    oidx_d   = oidx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    result_d = result_q;
    unique case (state_q)
      StLoadA: begin
        if (in_fire) begin
          a_d     = bus.in_data;
          state_d = StLoadB;
          // Lane 0 seeds the carry: 1 for subtract (two's complement), else 0.
          if (idx_q == '0) begin
            sub_d   = sub_in;
            carry_d = sub_in;
          end
        end
      end
      StLoadB: begin
        if (in_fire) begin
          b_d     = bus.in_data;
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (ena) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IdxW'(i)) result_d[i] = add_sum;
          end
          carry_d = add_cout;
          if (idx_q == LastIdx) begin
            oidx_d  = '0;
            state_d = StEmit;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLoadA;
          end
        end
      end
      StEmit: begin
        if (out_fire) begin
          if (oidx_q == LastIdx) state_d = StEmitC;
          else                   oidx_d  = oidx_q + 1'b1;
        end
      end
      StEmitC: begin
        if (out_fire) begin
          idx_d   = '0;
          carry_d = 1'b0;
          sub_d   = 1'b0;
          state_d = StLoadA;
        end
      end
      default: state_d = StLoadA;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoadA;
      idx_q   <= '0;
      oidx_q  <= '0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      live_q  <= 1'b0;
      for (int i = 0; i < NBYTES; i++) result_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      oidx_q   <= oidx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      live_q   <= 1'b1;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_adder_chain_sequencer.sv
// Directed bench for adder_chain_sequencer (NBYTES=2): table of operations plus hand-written
// sequences for latency, backpressure, mid-operation reset and ena freeze.
module tb_adder_chain_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       sub_s = 1'b0;
  logic       busy;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;

  int n_cmp = 0;
  int n_err = 0;

  adder_chain_sequencer_if ifc ();

  always #5 clk = ~clk;

  // External 8-bit adder datapath.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  adder_chain_sequencer #(.NBYTES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
`ifdef ADDER_SUB_MODE_EN
    .sub      (sub_s),
`endif
    .bus      (ifc.slave),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  ec;
  } vec_t;

`ifdef ADDER_SUB_MODE_EN
  localparam int NV = 6;
`else
  localparam int NV = 4;
`endif
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    int n = 0;
    @(negedge clk);
    ifc.in_data  = d;
    ifc.in_valid = 1'b1;
    sub_s        = s;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      @(posedge clk);
    end
    #1;
    ifc.in_valid = 1'b0;
    sub_s        = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] ed, input logic el, input string nm);
    int n = 0;
    @(negedge clk);
    ifc.out_ready = 1'b1;
    while (!ifc.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: out_valid got 0 expected 1", nm);
    end else begin
      check({nm, ".data"}, {24'h0, ifc.out_data}, {24'h0, ed});
      check({nm, ".last"}, {31'h0, ifc.out_last}, {31'h0, el});
      @(posedge clk);
    end
    #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    send_byte(a[7:0], s);
    send_byte(b[7:0], 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(b[15:8], 1'b0);
  endtask

  task automatic recv_op(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] ec,
                         input string nm);
    recv_byte(e0, 1'b0, {nm, ".b0"});
    recv_byte(e1, 1'b0, {nm, ".b1"});
    recv_byte(ec, 1'b1, {nm, ".c"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, e0: 8'h00, e1: 8'h00, ec: 8'h01};
    vecs[1] = '{a: 16'h00FF, b: 16'h0001, sub: 1'b0, e0: 8'h00, e1: 8'h01, ec: 8'h00};
    vecs[2] = '{a: 16'h8000, b: 16'h8000, sub: 1'b0, e0: 8'h00, e1: 8'h00, ec: 8'h01};
    vecs[3] = '{a: 16'h0000, b: 16'h0000, sub: 1'b0, e0: 8'h00, e1: 8'h00, ec: 8'h00};
`ifdef ADDER_SUB_MODE_EN
    vecs[4] = '{a: 16'h1000, b: 16'h0001, sub: 1'b1, e0: 8'hFF, e1: 8'h0F, ec: 8'h01};
    vecs[5] = '{a: 16'h0001, b: 16'h0002, sub: 1'b1, e0: 8'hFF, e1: 8'hFF, ec: 8'h00};
`endif

    ifc.in_data   = 8'h00;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("rst.out_data", {24'h0, ifc.out_data}, 32'h0);
    check("rst.out_last", {31'h0, ifc.out_last}, 32'h0);
    check("rst.add_a", {24'h0, add_a}, 32'h0);
    check("rst.add_b", {24'h0, add_b}, 32'h0);
    check("rst.add_cin", {31'h0, add_cin}, 32'h0);
    check("rst.busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("rst.in_ready", {31'h0, ifc.in_ready}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel.in_ready", {31'h0, ifc.in_ready}, 32'h1);
    check("rel.busy", {31'h0, busy}, 32'h0);

    // 0x1234 + 0x0FCD with carry and latency checks.
    send_op(16'h1234, 16'h0FCD, 1'b0);
    check("add1.cin_lane1", {31'h0, add_cin}, 32'h1);
    check("add1.lat_add_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("add1.lat_add_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    check("add1.lat_emit_valid", {31'h0, ifc.out_valid}, 32'h1);
    check("add1.emit_in_ready", {31'h0, ifc.in_ready}, 32'h0);
    recv_op(8'h01, 8'h22, 8'h00, "add1");

    // Backpressure in EMIT.
    send_op(16'h1234, 16'h0FCD, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ifc.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check("bp.out_valid", {31'h0, ifc.out_valid}, 32'h1);
      check("bp.out_data", {24'h0, ifc.out_data}, 32'h01);
      check("bp.in_ready", {31'h0, ifc.in_ready}, 32'h0);
      @(negedge clk);
    end
    recv_op(8'h01, 8'h22, 8'h00, "bp");

    // Reset after A0/B0 (lane 0 generates a carry that must be discarded).
    send_byte(8'h34, 1'b0);
    send_byte(8'hCD, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mrst.busy", {31'h0, busy}, 32'h0);
    check("mrst.add_a", {24'h0, add_a}, 32'h0);
    check("mrst.add_cin", {31'h0, add_cin}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    send_op(16'h0001, 16'h0001, 1'b0);
    recv_op(8'h02, 8'h00, 8'h00, "mrst");

    // ena low in LOAD_B: no transfer, b_reg holds (last B was 0x00).
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    ena          = 1'b0;
    ifc.in_data  = 8'h55;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ena0.in_ready", {31'h0, ifc.in_ready}, 32'h0);
      check("ena0.add_b", {24'h0, add_b}, 32'h00);
    end
    ena = 1'b1;
    #1 check("ena1.in_ready", {31'h0, ifc.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    check("ena1.add_b", {24'h0, add_b}, 32'h55);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    recv_op(8'h56, 8'h00, 8'h00, "ena");

    // Table-driven operations.
    for (int i = 0; i < NV; i++) begin
      send_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      recv_op(vecs[i].e0, vecs[i].e1, vecs[i].ec, $sformatf("vec%0d", i));
    end

    @(negedge clk);
    check("end.busy", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
